// File: rtl/mac_operand_buffer_if.sv
// mac_operand_buffer_if
//   Handshake bundle between the operand loader, the operand buffer and the
//   MAC stage.
//   Loader side : in_valid, in_ready, in_a, in_b
//   MAC side    : out_valid, out_ready, out_a, out_b
//   Modports    : slave  - the buffer (accepts pairs, presents the head pair)
//                 master - the environment (offers pairs, consumes the head)
interface mac_operand_buffer_if #(
  parameter int unsigned DataWidth = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DataWidth-1:0] in_a;
  logic [DataWidth-1:0] in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [DataWidth-1:0] out_a;
  logic [DataWidth-1:0] out_b;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b
  );
endinterface

// File: rtl/mac_operand_buffer.sv
// mac_operand_buffer
//   Circular buffer of (A, B) operand pairs in front of the MAC datapath.
//   Depth is 2**BufferWidth. The head pair is presented first-word
//   fall-through, so the MAC sees it without a separate read cycle.
//
//   Ports
//     clk     : clock, all state changes on the rising edge
//     reset   : asynchronous active-low reset of pointers, count, flag
//     flush   : synchronous clear of pointers and count
//     bus     : mac_operand_buffer_if.slave (loader and MAC handshakes)
//     count   : entries held, 0..depth
//     full    : count == depth
//     empty   : count == 0
//     ovf_err : sticky dropped-offer flag, only with OPERAND_BUFFER_OVF_EN
//
//   Optional feature macro: OPERAND_BUFFER_OVF_EN
module mac_operand_buffer #(
  parameter int unsigned BufferWidth = 2,
  parameter int unsigned DataWidth   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  mac_operand_buffer_if.slave    bus,
  output logic [BufferWidth:0]   count,
  output logic                   full,
  output logic                   empty
`ifdef OPERAND_BUFFER_OVF_EN
  ,
  output logic                   ovf_err
`endif
);

  localparam int unsigned Depth = 1 << BufferWidth;

  logic [2*DataWidth-1:0] mem [Depth];
  logic [BufferWidth-1:0] wr_ptr;
  logic [BufferWidth-1:0] rd_ptr;
  logic [BufferWidth:0]   count_q;
  logic                   push;
  logic                   pop;

  // Status and ready/valid come from the registered count only, so there is
  // no combinational path from in_valid or out_ready to the handshakes.
  always_comb begin
    count         = count_q;
    full          = (count_q == (BufferWidth+1)'(Depth));
    empty         = (count_q == '0);
    bus.in_ready  = !full;
    bus.out_valid = !empty;
    push          = bus.in_valid & !full;
    pop           = bus.out_ready & !empty;
    bus.out_a     = mem[rd_ptr][2*DataWidth-1:DataWidth];
    bus.out_b     = mem[rd_ptr][DataWidth-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + BufferWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + BufferWidth'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (BufferWidth+1)'(1);
        2'b01:   count_q <= count_q - (BufferWidth+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; writes are suppressed while reset or flush is active.
  always_ff @(posedge clk) begin
    if (push && !flush && reset) begin
      mem[wr_ptr] <= {bus.in_a, bus.in_b};
    end
  end

`ifdef OPERAND_BUFFER_OVF_EN
  // Any offer while full is a dropped pair; flush leaves the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_err <= 1'b0;
    end else if (bus.in_valid && full) begin
      ovf_err <= 1'b1;
    end
  end
`endif

endmodule
